// File: rtl/osd_cmd_bridge_if.sv
// Host word stream in, OSD command bus out. The bridge takes the slave modport
// and the host/OSD side takes the master modport.
interface osd_cmd_bridge_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        io_osd;
  logic        io_strobe;
  logic [15:0] io_din;

  modport master (output in_valid, in_data, in_last,
                  input  in_ready, io_osd, io_strobe, io_din);
  modport slave  (input  in_valid, in_data, in_last,
                  output in_ready, io_osd, io_strobe, io_din);
endinterface

// File: rtl/osd_cmd_bridge.sv
// Packetised 16-bit word stream -> paced OSD frame/strobe/data bus.
// Define OSD_CMD_BRIDGE_TMO_EN to enable the mid-packet starvation timeout.
module osd_cmd_bridge #(
  parameter int FIFO_AW   = 4,
  parameter int SETUP_CYC = 2,
  parameter int STRB_CYC  = 2,
  parameter int GAP_CYC   = 2,
  parameter int CS_GAP    = 4,
  parameter int TMO_CYC   = 1024
) (
  input  logic            clk_sys,
  input  logic            rst,
  osd_cmd_bridge_if.slave bus,
  output logic            busy,
  output logic [7:0]      pkt_cnt,
  output logic            err
);
  localparam int DEPTH    = 1 << FIFO_AW;
  localparam int ENDG_CYC = GAP_CYC + CS_GAP;
  localparam int M1       = (SETUP_CYC > STRB_CYC) ? SETUP_CYC : STRB_CYC;
  localparam int CNT_MAX  = (M1 > ENDG_CYC) ? M1 : ENDG_CYC;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  // Counter loads are N-1 so each state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STRB_LD  = CNT_W'(STRB_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] ENDG_LD  = CNT_W'(ENDG_CYC - 1);
  localparam logic [CNT_W-1:0] CS_MATCH = CNT_W'(CS_GAP);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (SETUP_CYC < 1 || STRB_CYC < 1 || GAP_CYC < 1 || CS_GAP < 1 || TMO_CYC < 1) begin : g_param_chk
    $error("osd_cmd_bridge: timing parameters must be >= 1");
  end

  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } osd_word_t;

  typedef enum logic [2:0] {IDLE, SETUP, STRB, GAP, ENDGAP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               cur_last;
  logic               osd_q, strb_q;
  logic [15:0]        din_q;
  logic               drop;

  osd_word_t          mem [DEPTH];
  osd_word_t          rd_word;
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   fill;
  logic               fifo_empty, push, pop;

  assign fifo_empty    = (fill == '0);
  assign bus.in_ready  = (fill != (FIFO_AW+1)'(DEPTH));
  assign push          = bus.in_valid & bus.in_ready;
  assign rd_word       = mem[rd_ptr];
  assign pop           = !fifo_empty && ((state == IDLE) || (state == GAP && cnt == '0));
  assign busy          = !fifo_empty || (state != IDLE);
  assign bus.io_osd    = osd_q;
  assign bus.io_strobe = strb_q;
  assign bus.io_din    = din_q;

  always_ff @(posedge clk_sys)
    if (push) mem[wr_ptr] <= '{last: bus.in_last, data: bus.in_data};

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   fill <= fill + (FIFO_AW+1)'(1);
        2'b01:   fill <= fill - (FIFO_AW+1)'(1);
        default: ;
      endcase
    end
  end

`ifdef OSD_CMD_BRIDGE_TMO_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  assign err  = 1'b0;
  assign drop = 1'b0;
`endif

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_last <= 1'b0;
      osd_q    <= 1'b0;
      strb_q   <= 1'b0;
      din_q    <= '0;
      pkt_cnt  <= '0;
`ifdef OSD_CMD_BRIDGE_TMO_EN
      err      <= 1'b0;
      drop     <= 1'b0;
      tmo_cnt  <= '0;
`endif
    end else begin
`ifdef OSD_CMD_BRIDGE_TMO_EN
      tmo_cnt <= '0;
`endif
      case (state)
        IDLE: if (!fifo_empty) begin
`ifdef OSD_CMD_BRIDGE_TMO_EN
          // Remainder of an aborted packet is swallowed up to its last word.
          if (drop) drop <= !rd_word.last;
          else
`endif
          begin
            din_q    <= rd_word.data;
            cur_last <= rd_word.last;
            osd_q    <= 1'b1;
            cnt      <= SETUP_LD;
            state    <= SETUP;
          end
        end
        SETUP: if (cnt == '0) begin
          strb_q <= 1'b1;
          cnt    <= STRB_LD;
          state  <= STRB;
        end else cnt <= cnt - CNT_ONE;
        STRB: if (cnt == '0) begin
          strb_q <= 1'b0;
          if (cur_last) begin
            cnt   <= ENDG_LD;
            state <= ENDGAP;
          end else begin
            cnt   <= GAP_LD;
            state <= GAP;
          end
        end else cnt <= cnt - CNT_ONE;
        GAP: if (cnt != '0) cnt <= cnt - CNT_ONE;
        else if (!fifo_empty) begin
          din_q    <= rd_word.data;
          cur_last <= rd_word.last;
          cnt      <= SETUP_LD;
          state    <= SETUP;
        end
`ifdef OSD_CMD_BRIDGE_TMO_EN
        else if (tmo_cnt == TMO_LAST) begin
          err   <= 1'b1;
          osd_q <= 1'b0;
          drop  <= 1'b1;
          cnt   <= CNT_W'(CS_GAP - 1);
          state <= ENDGAP;
        end else tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
        ENDGAP: begin
          // Frame select drops GAP_CYC cycles after the last strobe falls.
          if (cnt == CS_MATCH) osd_q <= 1'b0;
          if (cnt == '0) begin
            if (!drop) pkt_cnt <= pkt_cnt + 8'd1;
            state <= IDLE;
          end else cnt <= cnt - CNT_ONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_osd_cmd_bridge.sv
// Scoreboard bench for osd_cmd_bridge: words queued on accept, checked at each strobe rise.
`timescale 1ns/1ps
module tb_osd_cmd_bridge;
  logic       clk_sys = 1'b0;
  logic       rst = 1'b1;
  logic       busy, err;
  logic [7:0] pkt_cnt;

  osd_cmd_bridge_if bif();

  osd_cmd_bridge #(.TMO_CYC(64)) dut (
    .clk_sys(clk_sys), .rst(rst), .bus(bif),
    .busy(busy), .pkt_cnt(pkt_cnt), .err(err)
  );

  always #5 clk_sys = ~clk_sys;

  int          n_chk = 0, n_err = 0;
  logic [15:0] exp_q[$];
  int          len_q[$];
  int          cur_len = 0, exp_pkts = 0, n_acc = 0, full_at = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic l, input bit keep);
    int t = 0;
    bif.in_valid = 1'b1; bif.in_data = d; bif.in_last = l;
    while (!bif.in_ready && t < 1000) begin
      if (full_at < 0) full_at = n_acc;
      @(posedge clk_sys); #1; t++;
    end
    if (t == 1000) chk("in_ready_tmo", bif.in_ready, 1);
    if (keep) begin
      exp_q.push_back(d);
      cur_len++;
      if (l) begin len_q.push_back(cur_len); cur_len = 0; exp_pkts++; end
    end
    n_acc++;
    @(posedge clk_sys); #1;
    bif.in_valid = 1'b0; bif.in_last = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin @(posedge clk_sys); #1; t++; end while (busy && t < 3000);
    chk("idle", busy, 0);
    chk("pkt_cnt", pkt_cnt, exp_pkts & 8'hFF);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  // Monitor: strobe/data ordering, data stability, frame gap, strobes per frame.
  logic        p_strb = 1'b0, p_osd = 1'b0;
  logic [15:0] din_rise = '0;
  int          low_cnt = 100, pkt_rises = 0;

  always @(negedge clk_sys) begin
    if (rst) begin
      p_strb = 1'b0; p_osd = 1'b0; low_cnt = 100; pkt_rises = 0;
    end else begin
      if (bif.io_strobe) chk("strb_osd", bif.io_osd, 1);
      if (bif.io_strobe && !p_strb) begin
        pkt_rises++;
        if (exp_q.size() == 0) chk("strb_extra", exp_q.size(), 1);
        else chk("din", bif.io_din, exp_q.pop_front());
        din_rise = bif.io_din;
      end
      if (!bif.io_strobe && p_strb) chk("din_hold", bif.io_din, din_rise);
      if (bif.io_osd && !p_osd) chk("cs_gap_ge4", low_cnt >= 4, 1);
      if (!bif.io_osd && p_osd) begin
        if (len_q.size() == 0) chk("pkt_extra", len_q.size(), 1);
        else chk("pkt_strobes", pkt_rises, len_q.pop_front());
        pkt_rises = 0;
      end
      low_cnt = bif.io_osd ? 0 : low_cnt + 1;
      p_strb = bif.io_strobe;
      p_osd  = bif.io_osd;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int t;
    bif.in_valid = 1'b0; bif.in_data = '0; bif.in_last = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_osd", bif.io_osd, 0);
    chk("rst_strobe", bif.io_strobe, 0);
    chk("rst_din", bif.io_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(posedge clk_sys); #1;
    chk("rst_in_ready", bif.in_ready, 1);

    // Single 5-word packet
    send(16'h0041, 1'b0, 1'b1);
    send(16'h0000, 1'b0, 1'b1);
    send(16'h0010, 1'b0, 1'b1);
    send(16'h0008, 1'b0, 1'b1);
    send(16'h0004, 1'b1, 1'b1);
    wait_idle();

    // Back-to-back single-word packets
    send(16'h0040, 1'b1, 1'b1);
    send(16'h0021, 1'b1, 1'b1);
    wait_idle();

    // 40-word burst with valid held high; FIFO fills to 16 after 19 accepts
    full_at = -1; n_acc = 0;
    for (int i = 0; i < 40; i++)
      send((i == 0) ? 16'h2000 : 16'(i - 1), i == 39, 1'b1);
    chk("full_at", full_at, 19);
    wait_idle();

`ifdef OSD_CMD_BRIDGE_TMO_EN
    // Starvation timeout, then discard of the aborted packet's tail
    send(16'h0020, 1'b0, 1'b1);
    len_q.push_back(cur_len); cur_len = 0;
    repeat (20) @(posedge clk_sys);
    #1 chk("tmo_err_early", err, 0);
    repeat (180) @(posedge clk_sys);
    #1;
    chk("tmo_err", err, 1);
    chk("tmo_osd", bif.io_osd, 0);
    send(16'h0055, 1'b0, 1'b0);
    send(16'h0066, 1'b1, 1'b0);
    send(16'h0040, 1'b1, 1'b1);
    wait_idle();
`else
    // Mid-packet starvation: frame stays open, data held
    send(16'h0020, 1'b0, 1'b1);
    for (int i = 0; i < 500; i++) begin
      @(posedge clk_sys); #1;
      if (i % 100 == 99) begin
        chk("starve_osd", bif.io_osd, 1);
        chk("starve_din", bif.io_din, 16'h0020);
      end
    end
    send(16'h00AA, 1'b1, 1'b1);
    wait_idle();
    chk("err_tied", err, 0);
`endif

    // Asynchronous reset in the middle of a strobe
    send(16'h0041, 1'b0, 1'b1);
    send(16'h0001, 1'b0, 1'b1);
    send(16'h0002, 1'b1, 1'b1);
    t = 0;
    while (!bif.io_strobe && t < 100) begin @(posedge clk_sys); #1; t++; end
    chk("strobe_seen", bif.io_strobe, 1);
    rst = 1'b1;
    #1;
    chk("arst_strobe", bif.io_strobe, 0);
    chk("arst_osd", bif.io_osd, 0);
    exp_q.delete(); len_q.delete(); cur_len = 0; exp_pkts = 0;
    repeat (3) @(posedge clk_sys);
    #1 rst = 1'b0;
    @(posedge clk_sys); #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ready", bif.in_ready, 1);
    chk("post_rst_pkt_cnt", pkt_cnt, 0);
    send(16'h0040, 1'b1, 1'b1);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
